// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings plus the helpers the burst address generator needs
// to screen commands (page size, legal WRAP lengths, bytes per beat).
package axi4_pkg;

    typedef enum logic [1:0] {
        FIXED    = 2'b00,
        INCR     = 2'b01,
        WRAP     = 2'b10,
        RESERVED = 2'b11
    } AXBurst_t;

    typedef enum logic [2:0] {
        S1, S2, S4, S8, S16, S32, S64, S128
    } AXSize_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } XRESP_t;

    localparam int unsigned AXI4_PAGE_BYTES = 4096;
    localparam int unsigned AXI4_PAGE_BITS  = $clog2(AXI4_PAGE_BYTES);

    function automatic logic wrap_len_legal(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic [7:0] size_bytes(input AXSize_t size);
        return 8'd1 << size;
    endfunction

endpackage

// File: rtl/axi4_beat_strb.sv
// Byte-lane strobe for one beat: lanes from the address offset up to the end
// of the size-aligned window that contains it.
module axi4_beat_strb
    import axi4_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NB     = DATA_W / 8,
    parameter int LW     = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic [LW-1:0] addr_lo,
    input  AXSize_t       size,
    output logic [NB-1:0] strb
);

    logic [15:0] lo;
    logic [15:0] bytes;
    logic [15:0] win_end;

    // Oversized beats (error case) simply run the window off the top lane.
    always_comb begin
        lo      = 16'(addr_lo) & 16'(NB - 1);
        bytes   = 16'(size_bytes(size));
        win_end = (lo & ~(bytes - 16'd1)) + bytes;
        for (int i = 0; i < NB; i++) begin
            strb[i] = (16'(i) >= lo) && (16'(i) < win_end);
        end
    end

endmodule

// File: rtl/axi4_burst_addr_gen.sv
// Expands one AXI4 AR/AW command into a registered per-beat stream of
// address, strobe, index, last and response for FIXED/INCR/WRAP bursts.
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_len,
    input  logic [2:0]          cmd_size,
    input  logic [1:0]          cmd_burst,
    output logic                beat_valid,
    input  logic                beat_ready,
    output logic [ID_W-1:0]     beat_id,
    output logic [ADDR_W-1:0]   beat_addr,
    output logic [DATA_W/8-1:0] beat_strb,
    output logic [7:0]          beat_idx,
    output logic                beat_last,
    output logic [1:0]          beat_resp
);

    localparam int NB = DATA_W / 8;
    localparam int LW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(NB));

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     id_q;
    logic [7:0]          len_q;
    logic [7:0]          idx_q;
    AXSize_t             size_q;
    AXBurst_t            burst_q;
    logic                err_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [ADDR_W-1:0]   bytes;
    logic [ADDR_W-1:0]   cont_mask;
    logic [ADDR_W-1:0]   cmd_bytes;
    logic [ADDR_W:0]     incr_span;
    logic [ADDR_W:0]     incr_end;
    logic [NB-1:0]       strb_raw;
    logic                cmd_hs;
    logic                beat_hs;
    logic                cmd_err;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        beat_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = BURST;
            end
            BURST: begin
                beat_valid = 1'b1;
                if (beat_ready && beat_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_hs  = cmd_valid && cmd_ready;
    assign beat_hs = beat_valid && beat_ready;

    // Command screening; the page test uses one spare bit so a burst that
    // runs off the top of the address space also counts as a crossing.
    always_comb begin
        cmd_bytes = ADDR_W'(size_bytes(AXSize_t'(cmd_size)));
        incr_span = ((ADDR_W+1)'(cmd_len) + (ADDR_W+1)'(1)) << cmd_size;
        incr_end  = {1'b0, cmd_addr & ~(cmd_bytes - 1'b1)} + incr_span - (ADDR_W+1)'(1);
        cmd_err   = (AXBurst_t'(cmd_burst) == RESERVED)
                 || (AXBurst_t'(cmd_burst) == WRAP && !wrap_len_legal(cmd_len))
                 || (cmd_size > MAX_SIZE)
                 || (AXBurst_t'(cmd_burst) == INCR &&
                     incr_end[ADDR_W:AXI4_PAGE_BITS] != {1'b0, cmd_addr[ADDR_W-1:AXI4_PAGE_BITS]});
    end

    always_comb begin
        bytes     = ADDR_W'(size_bytes(size_q));
        cont_mask = ((ADDR_W'(len_q) + 1'b1) << size_q) - 1'b1;
        addr_nxt  = addr_q;
        if (!err_q) begin
            case (burst_q)
                INCR:    addr_nxt = (addr_q & ~(bytes - 1'b1)) + bytes;
                WRAP:    addr_nxt = (addr_q & ~cont_mask) | ((addr_q + bytes) & cont_mask);
                default: addr_nxt = addr_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q    <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            size_q  <= S1;
            burst_q <= FIXED;
            err_q   <= 1'b0;
            addr_q  <= '0;
        end else if (cmd_hs) begin
            id_q    <= cmd_id;
            len_q   <= cmd_len;
            idx_q   <= '0;
            size_q  <= AXSize_t'(cmd_size);
            burst_q <= AXBurst_t'(cmd_burst);
            err_q   <= cmd_err;
            addr_q  <= cmd_addr;
        end else if (beat_hs) begin
            idx_q   <= idx_q + 8'd1;
            addr_q  <= addr_nxt;
        end
    end

    axi4_beat_strb #(.DATA_W(DATA_W)) u_strb (
        .addr_lo (addr_q[LW-1:0]),
        .size    (size_q),
        .strb    (strb_raw)
    );

    // Gated by state so the reset view shows all-zero beat fields.
    assign beat_id   = id_q;
    assign beat_addr = addr_q;
    assign beat_idx  = idx_q;
    assign beat_strb = beat_valid ? strb_raw : '0;
    assign beat_last = (state_q == BURST) && (idx_q == len_q);
    assign beat_resp = err_q ? 2'(SLVERR) : 2'(OKAY);

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Randomised bench for axi4_burst_addr_gen: a closed-form beat model fills an
// expectation queue on each command handshake and every cycle is compared.
module tb_axi4_burst_addr_gen;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  strb;
        logic [7:0]  idx;
        logic        last;
        logic [1:0]  resp;
        logic [3:0]  id;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_id = '0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [2:0]  cmd_size = '0;
    logic [1:0]  cmd_burst = '0;
    logic        beat_valid;
    logic        beat_ready = 1'b0;
    logic [3:0]  beat_id;
    logic [31:0] beat_addr;
    logic [7:0]  beat_strb;
    logic [7:0]  beat_idx;
    logic        beat_last;
    logic [1:0]  beat_resp;

    int    vectors = 0;
    int    errs = 0;
    bit    started = 0;
    int    rdy_pct = 100;
    bit    hold_mode = 0;
    int    hold_cnt = 0;
    beat_t exp_q[$];
    beat_t gen_q[$];

    axi4_burst_addr_gen #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_id(beat_id),
        .beat_addr(beat_addr), .beat_strb(beat_strb), .beat_idx(beat_idx),
        .beat_last(beat_last), .beat_resp(beat_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    // Closed-form beat list for one command on a 64-bit bus.
    function automatic void gen(input logic [3:0] id, input logic [31:0] a0,
                                input int len, input int size, input int burst);
        longint bytes, aligned, c, a, lo, wend;
        bit     err;
        beat_t  b;
        bytes   = longint'(1) << size;
        aligned = longint'(a0) - (longint'(a0) % bytes);
        err = (burst == 3)
           || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15))
           || (size > 3)
           || (burst == 1 && ((aligned + (len + 1) * bytes - 1) / 4096 != longint'(a0) / 4096));
        c = (len + 1) * bytes;
        gen_q.delete();
        for (int k = 0; k <= len; k++) begin
            if (err || burst == 0)  a = longint'(a0);
            else if (burst == 1)    a = (k == 0) ? longint'(a0) : aligned + k * bytes;
            else                    a = (longint'(a0) - longint'(a0) % c) + ((longint'(a0) + k * bytes) % c);
            lo   = a % 8;
            wend = (lo / bytes) * bytes + bytes;
            b.addr = 32'(a);
            for (int i = 0; i < 8; i++) b.strb[i] = (i >= lo) && (i < wend);
            b.idx  = 8'(k);
            b.last = (k == len);
            b.resp = err ? 2'd2 : 2'd0;
            b.id   = id;
            gen_q.push_back(b);
        end
    endfunction

    // Handshake monitor: old register values are read here, before the NBA update.
    always @(posedge clk) begin
        if (rst) exp_q.delete();
        else begin
            if (beat_valid && beat_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (cmd_valid && cmd_ready) begin
                gen(cmd_id, cmd_addr, int'(cmd_len), int'(cmd_size), int'(cmd_burst));
                foreach (gen_q[i]) exp_q.push_back(gen_q[i]);
            end
        end
    end

    always @(negedge clk) begin
        if (started && !rst) begin
            chk("cmd_ready", 64'(cmd_ready), 64'(exp_q.size() == 0));
            chk("beat_valid", 64'(beat_valid), 64'(exp_q.size() != 0));
            if (beat_valid && exp_q.size() != 0) begin
                chk("beat_addr", 64'(beat_addr), 64'(exp_q[0].addr));
                chk("beat_strb", 64'(beat_strb), 64'(exp_q[0].strb));
                chk("beat_idx",  64'(beat_idx),  64'(exp_q[0].idx));
                chk("beat_last", 64'(beat_last), 64'(exp_q[0].last));
                chk("beat_resp", 64'(beat_resp), 64'(exp_q[0].resp));
                chk("beat_id",   64'(beat_id),   64'(exp_q[0].id));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (hold_mode && beat_valid && beat_idx == 8'd1 && hold_cnt < 5) begin
            beat_ready = 1'b0;
            hold_cnt++;
        end else begin
            beat_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [3:0] id, input logic [31:0] a, input int len,
                            input int size, input int burst);
        int n = 0;
        while (!cmd_ready && n < 3000) begin tick(); n++; end
        if (n >= 3000) begin
            vectors++; errs++;
            $display("FAIL cmd_wait: cmd_ready still low after %0d cycles", n);
        end
        cmd_valid = 1'b1;
        cmd_id = id; cmd_addr = a; cmd_len = 8'(len); cmd_size = 3'(size); cmd_burst = 2'(burst);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && n < 5000) begin tick(); n++; end
        if (n >= 5000) begin
            vectors++; errs++;
            $display("FAIL idle_wait: burst still active after %0d cycles", n);
        end
    endtask

    task automatic wait_idx(input logic [7:0] want);
        int n = 0;
        while (!(beat_valid && beat_idx == want) && n < 200) begin tick(); n++; end
        if (n >= 200) begin
            vectors++; errs++;
            $display("FAIL idx_wait: beat_idx %0d never seen", want);
        end
    endtask

    initial begin
        logic [31:0] ia[4];
        logic [7:0]  is[4];
        logic [31:0] wa[4];
        logic [31:0] held;
        int len, size, burst;
        logic [31:0] a;

        // Pin the model against hand-derived beats.
        ia = '{32'h1002, 32'h1004, 32'h1008, 32'h100C};
        is = '{8'h0C, 8'hF0, 8'h0F, 8'hF0};
        gen(4'h1, 32'h1002, 3, 2, 1);
        chk("pin_incr_n", 64'(gen_q.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk("pin_incr_addr", 64'(gen_q[k].addr), 64'(ia[k]));
            chk("pin_incr_strb", 64'(gen_q[k].strb), 64'(is[k]));
            chk("pin_incr_resp", 64'(gen_q[k].resp), 64'd0);
        end
        chk("pin_incr_last3", 64'(gen_q[3].last), 64'd1);
        chk("pin_incr_last2", 64'(gen_q[2].last), 64'd0);
        wa = '{32'h1018, 32'h1000, 32'h1008, 32'h1010};
        gen(4'h2, 32'h1018, 3, 3, 2);
        for (int k = 0; k < 4; k++) begin
            chk("pin_wrap_addr", 64'(gen_q[k].addr), 64'(wa[k]));
            chk("pin_wrap_strb", 64'(gen_q[k].strb), 64'hFF);
        end
        gen(4'h3, 32'h0FF8, 1, 3, 1);
        chk("pin_page_n", 64'(gen_q.size()), 64'd2);
        chk("pin_page_addr", 64'(gen_q[1].addr), 64'h0FF8);
        chk("pin_page_resp", 64'(gen_q[1].resp), 64'd2);
        gen(4'h4, 32'h20, 2, 3, 0);
        chk("pin_fixed_addr", 64'(gen_q[2].addr), 64'h20);
        chk("pin_fixed_last", 64'(gen_q[2].last), 64'd1);

        repeat (3) tick();
        rst = 1'b0;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_beat_valid", 64'(beat_valid), 64'd0);
        chk("rst_beat_addr", 64'(beat_addr), 64'd0);
        chk("rst_beat_strb", 64'(beat_strb), 64'd0);
        chk("rst_beat_idx", 64'(beat_idx), 64'd0);
        chk("rst_beat_last", 64'(beat_last), 64'd0);
        chk("rst_beat_resp", 64'(beat_resp), 64'd0);
        chk("rst_beat_id", 64'(beat_id), 64'd0);
        started = 1;

        // Directed cases, full throughput.
        rdy_pct = 100;
        send_cmd(4'h1, 32'h1002, 3, 2, 1);
        chk("latency_valid", 64'(beat_valid), 64'd1);
        wait_idle();
        send_cmd(4'h2, 32'h1018, 3, 3, 2); wait_idle();
        send_cmd(4'h3, 32'h0020, 2, 3, 0); wait_idle();
        send_cmd(4'h4, 32'h0040, 1, 3, 3); wait_idle();
        send_cmd(4'h5, 32'h0100, 2, 2, 2); wait_idle();
        send_cmd(4'h6, 32'h0203, 3, 4, 1); wait_idle();
        send_cmd(4'h7, 32'h0FF8, 1, 3, 1); wait_idle();
        send_cmd(4'h8, 32'h0555, 0, 0, 1); wait_idle();

        // Backpressure on beat 1.
        hold_mode = 1; hold_cnt = 0;
        send_cmd(4'h9, 32'h2004, 3, 2, 1);
        wait_idx(8'd1);
        held = beat_addr;
        repeat (3) tick();
        chk("hold_addr", 64'(beat_addr), 64'(held));
        chk("hold_idx", 64'(beat_idx), 64'd1);
        wait_idle();
        hold_mode = 0;

        // Reset in the middle of a burst.
        send_cmd(4'hA, 32'h3000, 3, 2, 1);
        wait_idx(8'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", 64'(beat_valid), 64'd0);
        chk("midrst_ready", 64'(cmd_ready), 64'd1);
        send_cmd(4'hB, 32'h3100, 1, 3, 1);
        chk("midrst_idx0", 64'(beat_idx), 64'd0);
        wait_idle();

        // Random commands with random backpressure.
        rdy_pct = 70;
        for (int t = 0; t < 80; t++) begin
            burst = $urandom_range(0, 3);
            size  = $urandom_range(0, 4);
            len   = ($urandom_range(0, 1) == 1 && burst == 2) ? (2 << $urandom_range(0, 3)) - 1
                                                               : $urandom_range(0, 15);
            a = $urandom();
            if ($urandom_range(0, 3) == 0) a = {a[31:12], 12'hFC0} | 32'($urandom_range(0, 63));
            send_cmd(4'($urandom()), a, len, size, burst);
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
